serial_add16: RTL



---
 rtl/serial_add16.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/serial_add16.sv
// Nibble-serial adder: one 4-bit ripple-carry slice per clock, with the carry
// between nibbles held in a register so the combinational path is a single rca4b.

module rca4b (
  output logic [3:0] sum,
  output logic       c_out,
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       c_in
);

  logic [4:0] c;

  assign c[0] = c_in;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign c_out = c[4];

endmodule

module serial_add16 #(
  parameter int N_NIB = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*N_NIB-1:0]   a,
  input  logic [4*N_NIB-1:0]   b,
  input  logic                 c_in,
  output logic                 busy,
  output logic                 done,
  output logic [4*N_NIB-1:0]   sum,
  output logic                 c_out,
  output logic [1:0]           state_dbg
);

  localparam int         W    = 4 * N_NIB;
  localparam logic [2:0] LAST = 3'(N_NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   op_a_q, op_b_q, work_q, work_d;
  logic [W-1:0]   sum_q;
  logic           c_out_q;
  logic           carry_q;
  logic [2:0]     cnt_q;
  logic [3:0]     nib_a, nib_b;
  logic [3:0]     rca_sum;
  logic           rca_cout;
  logic           last_nib;

  // Handshake: a request is taken on any rising edge where start=1 and busy=0;
  // while busy=1 start is ignored (no queueing), and done marks the one cycle
  // in which the new sum/c_out first become visible.

  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int i = 0; i < N_NIB; i++) begin
      if (cnt_q == 3'(i)) begin
        nib_a = op_a_q[i*4 +: 4];
        nib_b = op_b_q[i*4 +: 4];
      end
    end
  end

  rca4b u_rca (
    .sum   (rca_sum),
    .c_out (rca_cout),
    .x     (nib_a),
    .y     (nib_b),
    .c_in  (carry_q)
  );

  // Work word with the current slice merged in, so the final nibble can be
  // published to sum on the same edge it is computed.
  always_comb begin
    work_d = work_q;
    for (int i = 0; i < N_NIB; i++) begin
      if (cnt_q == 3'(i)) begin
        work_d[i*4 +: 4] = rca_sum;
      end
    end
  end

  assign last_nib = (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_nib) begin
          state_d = DONE;
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a_q  <= '0;
      op_b_q  <= '0;
      work_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= 3'd0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            op_a_q  <= a;
            op_b_q  <= b;
            carry_q <= c_in;
            cnt_q   <= 3'd0;
            work_q  <= '0;
          end
        end
        RUN: begin
          work_q  <= work_d;
          carry_q <= rca_cout;
          if (last_nib) begin
            sum_q   <= work_d;
            c_out_q <= rca_cout;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign state_dbg = state_q;

endmodule
